// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Owns the control registers reg_0..reg_4 and shares their single write port
// between two requesters: A (SPI frame decoder) and B (on-chip local writer).
// Arbitration is round-robin over a valid/ready handshake, one write per
// cycle. An accepted write is captured in a stage register and committed on
// the following clock edge. Writes to addresses >= NUM_REGS are accepted but
// dropped, and a saturating counter records them. While hold is high, no new
// request is accepted. A write that is already staged still commits.
//
// Ports
//   m_clk           system clock, rising edge
//   rst             synchronous reset, active-high
//   hold            forces a_ready/b_ready low
//   a_valid/a_ready requester A handshake
//   a_addr/a_data   requester A address/data
//   b_valid/b_ready requester B handshake
//   b_addr/b_data   requester B address/data
//   reg_0..reg_4    register contents
//   wr_strobe       one-cycle pulse when a register is updated
//   wr_addr         address of the most recent committed register write
//   last_grant      0 = A won the most recent grant, 1 = B won
//   bad_addr_count  saturating count of rejected writes
//
// NUM_REGS must be at least 5 because reg_0..reg_4 are fixed output ports.
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
   parameter int NUM_REGS = 5,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 8
) (
   input  logic              m_clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic [DATA_W-1:0] reg_0,
   output logic [DATA_W-1:0] reg_1,
   output logic [DATA_W-1:0] reg_2,
   output logic [DATA_W-1:0] reg_3,
   output logic [DATA_W-1:0] reg_4,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              last_grant,
   output logic [CNT_W-1:0]  bad_addr_count
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              r_last_grant;
   logic              r_stg_valid;
   logic [ADDR_W-1:0] r_stg_addr;
   logic [DATA_W-1:0] r_stg_data;
   logic              r_wr_strobe;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [CNT_W-1:0]  r_bad_cnt;

   logic              w_a_ready;
   logic              w_b_ready;
   logic              w_hs_a;
   logic              w_hs_b;
   logic              w_hs;
   logic              w_stg_in_range;

   // Grant decision: hold blocks both sides, and a lone requester always wins.
   // Under contention, the side not named by last_grant wins.
   always_comb begin
      w_a_ready = 1'b0;
      w_b_ready = 1'b0;
      if (hold) begin
         w_a_ready = 1'b0;
         w_b_ready = 1'b0;
      end else if (a_valid && b_valid) begin
         if (r_last_grant) begin
            w_a_ready = 1'b1;
         end else begin
            w_b_ready = 1'b1;
         end
      end else begin
         w_a_ready = a_valid;
         w_b_ready = b_valid;
      end
   end

   assign w_hs_a = a_valid & w_a_ready;
   assign w_hs_b = b_valid & w_b_ready;
   assign w_hs   = w_hs_a | w_hs_b;

   // Full-width compare, so addresses above NUM_REGS never alias onto a register.
   assign w_stg_in_range = (r_stg_addr < ADDR_W'(NUM_REGS));

   // Stage register: captures the granted write and remembers the winner.
   always_ff @(posedge m_clk) begin
      if (rst) begin
         r_stg_valid  <= 1'b0;
         r_stg_addr   <= {ADDR_W{1'b0}};
         r_stg_data   <= {DATA_W{1'b0}};
         r_last_grant <= 1'b1;
      end else begin
         r_stg_valid <= w_hs;
         if (w_hs) begin
            r_stg_addr   <= w_hs_b ? b_addr : a_addr;
            r_stg_data   <= w_hs_b ? b_data : a_data;
            r_last_grant <= w_hs_b;
         end
      end
   end

   // Commit stage: applies the staged write, or counts it as rejected.
   // Hold has no effect here, so a staged write always finishes.
   always_ff @(posedge m_clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= {DATA_W{1'b0}};
         end
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= {ADDR_W{1'b0}};
         r_bad_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_wr_strobe <= 1'b0;
         if (r_stg_valid) begin
            if (w_stg_in_range) begin
               // An equality loop avoids indexing the array with a wider address.
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (r_stg_addr == ADDR_W'(i)) begin
                     r_regs[i] <= r_stg_data;
                  end
               end
               r_wr_strobe <= 1'b1;
               r_wr_addr   <= r_stg_addr;
            end else if (r_bad_cnt != {CNT_W{1'b1}}) begin
               r_bad_cnt <= r_bad_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign a_ready        = w_a_ready;
   assign b_ready        = w_b_ready;
   assign reg_0          = r_regs[0];
   assign reg_1          = r_regs[1];
   assign reg_2          = r_regs[2];
   assign reg_3          = r_regs[3];
   assign reg_4          = r_regs[4];
   assign wr_strobe      = r_wr_strobe;
   assign wr_addr        = r_wr_addr;
   assign last_grant     = r_last_grant;
   assign bad_addr_count = r_bad_cnt;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Directed scenarios followed by randomized traffic. Each cycle is checked
// against a behavioural model that keeps the registers in an array, holds
// the accepted-but-not-yet-committed write as a single pending entry, and
// derives grants from the round-robin rules.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

   logic       m_clk = 1'b0;
   logic       rst = 1'b0;
   logic       hold = 1'b0;
   logic       a_valid = 1'b0;
   logic       a_ready;
   logic [6:0] a_addr = 7'd0;
   logic [7:0] a_data = 8'd0;
   logic       b_valid = 1'b0;
   logic       b_ready;
   logic [6:0] b_addr = 7'd0;
   logic [7:0] b_data = 8'd0;
   logic [7:0] reg_0, reg_1, reg_2, reg_3, reg_4;
   logic       wr_strobe;
   logic [6:0] wr_addr;
   logic       last_grant;
   logic [7:0] bad_addr_count;

   reg_write_arbiter dut (
      .m_clk(m_clk), .rst(rst), .hold(hold),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3), .reg_4(reg_4),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .last_grant(last_grant),
      .bad_addr_count(bad_addr_count)
   );

   always #5 m_clk = ~m_clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   int  m_regs [5];
   int  m_cnt;
   bit  m_last;
   bit  m_pend;
   int  m_pend_addr;
   int  m_pend_data;
   bit  m_strobe;
   int  m_wr_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_regs[i] = 0;
      m_cnt = 0; m_last = 1'b1; m_pend = 1'b0;
      m_pend_addr = 0; m_pend_data = 0; m_strobe = 1'b0; m_wr_addr = 0;
   endtask

   // One clock cycle: drive, check the grant, take the edge, update the model, check state.
   task automatic step(input bit r, input bit h,
                       input bit av, input int aa, input int ad,
                       input bit bv, input int ba, input int bd,
                       output bit acc_a, output bit acc_b);
      bit er_a, er_b;
      int got_regs [5];
      @(negedge m_clk);
      rst = r; hold = h;
      a_valid = av; a_addr = 7'(aa); a_data = 8'(ad);
      b_valid = bv; b_addr = 7'(ba); b_data = 8'(bd);
      #1;
      er_a = 1'b0; er_b = 1'b0;
      if (!h) begin
         if (av && bv) begin
            if (m_last) er_a = 1'b1; else er_b = 1'b1;
         end else begin
            er_a = av; er_b = bv;
         end
      end
      chk("a_ready", a_ready, er_a);
      chk("b_ready", b_ready, er_b);
      acc_a = av && er_a;
      acc_b = bv && er_b;
      @(posedge m_clk);
      #1;
      if (r) begin
         model_reset();
      end else begin
         m_strobe = 1'b0;
         if (m_pend) begin
            if (m_pend_addr < 5) begin
               m_regs[m_pend_addr] = m_pend_data;
               m_strobe = 1'b1;
               m_wr_addr = m_pend_addr;
            end else if (m_cnt < 255) begin
               m_cnt++;
            end
         end
         m_pend = acc_a || acc_b;
         if (acc_b) begin
            m_pend_addr = ba; m_pend_data = bd; m_last = 1'b1;
         end else if (acc_a) begin
            m_pend_addr = aa; m_pend_data = ad; m_last = 1'b0;
         end
      end
      got_regs[0] = reg_0; got_regs[1] = reg_1; got_regs[2] = reg_2;
      got_regs[3] = reg_3; got_regs[4] = reg_4;
      for (int i = 0; i < 5; i++) chk($sformatf("reg_%0d", i), got_regs[i], m_regs[i]);
      chk("wr_strobe", wr_strobe, m_strobe);
      if (m_strobe) chk("wr_addr", wr_addr, m_wr_addr);
      chk("last_grant", last_grant, m_last);
      chk("bad_addr_count", bad_addr_count, m_cnt);
   endtask

   task automatic idle(output bit ga, output bit gb);
      step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, ga, gb);
   endtask

   task automatic do_reset(output bit ga, output bit gb);
      step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, ga, gb);
      step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, ga, gb);
   endtask

   initial begin
      bit ga, gb;
      bit av, bv, h, r;
      int aa, ad, ba, bd;
      string grants;
      model_reset();

      // Reset
      do_reset(ga, gb);
      chk("rst_last_grant", last_grant, 1'b1);
      chk("rst_count", bad_addr_count, 8'd0);

      // Single write from A
      step(1'b0, 1'b0, 1'b1, 2, 8'hA5, 1'b0, 0, 0, ga, gb);
      chk("single_accept", ga, 1'b1);
      idle(ga, gb);
      chk("single_reg2", reg_2, 8'hA5);
      chk("single_strobe", wr_strobe, 1'b1);
      chk("single_wr_addr", wr_addr, 7'd2);

      // Contention from a fresh reset: A, B, A, B
      do_reset(ga, gb);
      grants = "";
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 0, 8'h11, 1'b1, 1, 8'h22, ga, gb);
         grants = {grants, ga ? "A" : (gb ? "B" : "-")};
         if (i > 0) chk("contend_strobe", wr_strobe, 1'b1);
      end
      chk("contend_order", (grants == "ABAB") ? 1 : 0, 1);
      idle(ga, gb);
      chk("contend_strobe_last", wr_strobe, 1'b1);
      chk("contend_reg0", reg_0, 8'h11);
      chk("contend_reg1", reg_1, 8'h22);

      // Invalid addresses and saturation of the counter
      do_reset(ga, gb);
      step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 7, 8'hFF, ga, gb);
      chk("bad_accept", gb, 1'b1);
      idle(ga, gb);
      chk("bad_strobe", wr_strobe, 1'b0);
      chk("bad_count1", bad_addr_count, 8'd1);
      for (int i = 0; i < 300; i++)
         step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, $urandom_range(5, 127), $urandom_range(0, 255), ga, gb);
      idle(ga, gb);
      chk("bad_count_sat", bad_addr_count, 8'd255);

      // Hold blocks acceptance, and release lets the write through
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b1, 3, 8'h5A, 1'b0, 0, 0, ga, gb);
         chk("hold_no_accept", ga, 1'b0);
      end
      chk("hold_reg3", reg_3, 8'h00);
      step(1'b0, 1'b0, 1'b1, 3, 8'h5A, 1'b0, 0, 0, ga, gb);
      chk("hold_release_accept", ga, 1'b1);
      step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, ga, gb);
      chk("hold_inflight_reg3", reg_3, 8'h5A);

      // Reset while a write is in flight
      step(1'b0, 1'b0, 1'b1, 4, 8'h3C, 1'b0, 0, 0, ga, gb);
      step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, ga, gb);
      chk("rstmid_reg4", reg_4, 8'h00);
      chk("rstmid_strobe", wr_strobe, 1'b0);
      chk("rstmid_last", last_grant, 1'b1);
      idle(ga, gb);
      chk("rstmid_reg4_after", reg_4, 8'h00);

      // Randomized traffic; requests stay stable until accepted, with rare withdrawals
      av = 1'b0; bv = 1'b0; aa = 0; ad = 0; ba = 0; bd = 0;
      for (int i = 0; i < 1500; i++) begin
         if (!av || $urandom_range(0, 15) == 0) begin
            av = ($urandom_range(0, 2) != 0);
            aa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 7);
            ad = $urandom_range(0, 255);
         end
         if (!bv || $urandom_range(0, 15) == 0) begin
            bv = ($urandom_range(0, 2) != 0);
            ba = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 7);
            bd = $urandom_range(0, 255);
         end
         h = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 99) == 0);
         step(r, h, av, aa, ad, bv, ba, bd, ga, gb);
         if (ga) av = 1'b0;
         if (gb) bv = 1'b0;
      end
      idle(ga, gb);
      idle(ga, gb);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
